// File: rtl/aes_pkg.sv
// Shared AES types and helpers for the iterative AES-128 engine.
// FSM encoding, RCON table, GF(2^8) arithmetic, S-box and slice helpers.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  localparam int NR_DEF = 10;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    unique case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Inverse as x^254 (x^2 * x^4 * ... * x^128), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] b;
    sq = x;
    b  = 8'h01;
    for (int k = 0; k < 7; k++) begin
      sq = gf_mul(sq, sq);
      b  = gf_mul(b, sq);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] get_byte(
    input logic [127:0] s,
    input int           i
  );
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [31:0] get_word(
    input logic [127:0] s,
    input int           c
  );
    return s[127-32*c -: 32];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes128_round_ctrl_datapath.sv
// Combinational AES round blocks: sub_bytes, shift_rows, mix_columns.
// State is column-major, byte i = [127-8i -: 8], i = 4*col + row.
module sub_bytes
  import aes_pkg::*;
(
  input  logic [127:0] state,
  output logic [127:0] result
);
  for (genvar i = 0; i < 16; i++) begin : g_sb
    assign result[127-8*i -: 8] = sbox(get_byte(state, i));
  end
endmodule

module shift_rows (
  input  logic [127:0] state,
  output logic [127:0] result
);
  for (genvar c = 0; c < 4; c++) begin : g_c
    for (genvar r = 0; r < 4; r++) begin : g_r
      assign result[127-8*(4*c+r) -: 8] =
        state[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end
endmodule

module mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] state,
  output logic [127:0] result
);
  for (genvar c = 0; c < 4; c++) begin : g_mc
    assign result[127-32*c -: 32] = mix_col(get_word(state, c));
  end
endmodule

// File: rtl/aes_key_step.sv
// AES-128 key expansion step: one round key to the next.
// Holds the four SubWord S-boxes on the rotated last word.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] rkey,
  input  logic [7:0]   rc,
  output logic [127:0] nkey
);
  logic [31:0] w0, w1, w2, w3, t;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = get_word(rkey, 0);
  assign w1 = get_word(rkey, 1);
  assign w2 = get_word(rkey, 2);
  assign w3 = get_word(rkey, 3);

  assign t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign nkey = {n0, n1, n2, n3};
endmodule

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, valid/ready both sides.
// AES_ROUND_TRACE_EN adds trace_rnd/trace_valid and masks out_text.
module aes128_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = NR_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  input  logic [127:0] in_text,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef AES_ROUND_TRACE_EN
  output logic [3:0]   trace_rnd,
  output logic         trace_valid,
`endif
  output logic [127:0] out_text,
  output logic         busy
);
  localparam logic [3:0] NR4 = 4'(NR);

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, rkey_q;
  logic [3:0]   rnd_q;
  logic [127:0] nk, sb, sr, mc;

  aes_key_step u_key (
    .rkey (rkey_q),
    .rc   (rcon(rnd_q)),
    .nkey (nk)
  );

  sub_bytes   u_sb (.state(state_q), .result(sb));
  shift_rows  u_sr (.state(sb),      .result(sr));
  mix_columns u_mc (.state(sr),      .result(mc));

  // Next-state logic for the IDLE/ROUND/DONE sequencer.
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:    if (in_valid) fsm_d = ROUND;
      ROUND:   if (rnd_q == NR4) fsm_d = DONE;
      DONE:    if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // State, round key and round counter; final round skips mix_columns.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rkey_q  <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q <= fsm_d;
      unique case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            state_q <= in_text ^ in_key;
            rkey_q  <= in_key;
            rnd_q   <= 4'd1;
          end
        end
        ROUND: begin
          rkey_q <= nk;
          if (rnd_q == NR4) begin
            state_q <= sr ^ nk;
          end else begin
            state_q <= mc ^ nk;
            rnd_q   <= rnd_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q == ROUND) || (fsm_q == DONE);

`ifdef AES_ROUND_TRACE_EN
  assign trace_rnd   = rnd_q;
  assign trace_valid = (fsm_q == ROUND);
  assign out_text    = out_valid ? state_q : '0;
`else
  assign out_text    = state_q;
`endif
endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Directed bench for aes128_round_ctrl using FIPS-197 vectors.
// Inputs change and outputs are sampled on the falling edge.
module tb_aes128_round_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_key;
  logic [127:0] in_text;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_text;
  logic         busy;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  always #5 clk = ~clk;

  aes128_round_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_key    (in_key),
    .in_text   (in_text),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_text  (out_text),
    .busy      (busy)
  );

  function automatic logic [127:0] junk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Accept one block, then count edges until out_valid (bounded).
  task automatic run_block(
    input  logic [127:0] k,
    input  logic [127:0] p,
    output logic [127:0] res,
    output int           lat
  );
    in_key   = k;
    in_text  = p;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    res = out_text;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    end
    checks++;
    if (out_text !== 128'h0) begin
      errors++;
      $display("FAIL reset_text: got %h want 0", out_text);
    end
  endtask

  task automatic test_vector(
    input string        name,
    input logic [127:0] k,
    input logic [127:0] p,
    input logic [127:0] c
  );
    logic [127:0] res;
    int           lat;
    run_block(k, p, res, lat);
    checks++;
    if (res !== c) begin
      errors++;
      $display("FAIL %s_text: got %h want %h", name, res, c);
    end
    checks++;
    if (lat !== 10) begin
      errors++;
      $display("FAIL %s_latency: got %0d want 10", name, lat);
    end
    release_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b want 0 1",
               name, out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] res;
    int           lat;
    int           bad;
    run_block(KC, PC, res, lat);
    checks++;
    if (res !== CC || lat !== 10) begin
      errors++;
      $display("FAIL bp_result: got %h lat %0d want %h lat 10", res, lat, CC);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_key   = junk();
      in_text  = junk();
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_text !== CC || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: v=%b rdy=%b text=%h want 1 0 %h",
                 i, out_valid, in_ready, out_text, CC);
      end
    end
    in_valid = 1'b0;
    release_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    out_ready = 1'b1;
    in_key    = KC;
    in_text   = PC;
    in_valid  = 1'b1;
    tick();
    in_key  = KB;
    in_text = PB;
    e = 0;
    while (!out_valid && e < 40) begin
      tick();
      e++;
    end
    checks++;
    if (e !== 10 || out_text !== CC) begin
      errors++;
      $display("FAIL b2b_first: got %h at %0d want %h at 10", out_text, e, CC);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_rdy: in_ready=%b want 0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: out_valid=%b in_ready=%b want 0 1",
               out_valid, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept2: busy=%b in_ready=%b want 1 0",
               busy, in_ready);
    end
    e = 0;
    while (!out_valid && e < 40) begin
      tick();
      e++;
    end
    checks++;
    if (e !== 10 || out_text !== CB) begin
      errors++;
      $display("FAIL b2b_second: got %h at %0d want %h at 10", out_text, e, CB);
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end: out_valid=%b in_ready=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    in_key   = KB;
    in_text  = PB;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: busy=%b want 1", busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_text !== 128'h0) begin
      errors++;
      $display("FAIL mid_reset: rdy=%b v=%b text=%h want 1 0 0",
               in_ready, out_valid, out_text);
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mid_no_pulse: out_valid cycles=%0d want 0", seen);
    end
    test_vector("mid_c1", KC, PC, CC);
  endtask

  task automatic test_reset_vs_accept();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_key   = KB;
    in_text  = PB;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_text !== 128'h0) begin
      errors++;
      $display("FAIL rst_wins: busy=%b rdy=%b text=%h want 0 1 0",
               busy, in_ready, out_text);
    end
  endtask

  task automatic test_ignored_input();
    int lat;
    in_key   = KB;
    in_text  = PB;
    in_valid = 1'b1;
    tick();
    lat = 0;
    while (!out_valid && lat < 40) begin
      in_valid = (lat < 7) ? ~in_valid : 1'b0;
      in_key   = junk();
      in_text  = junk();
      tick();
      lat++;
    end
    in_valid = 1'b0;
    checks++;
    if (out_text !== CB || lat !== 10) begin
      errors++;
      $display("FAIL ignored_in: got %h lat %0d want %h lat 10",
               out_text, lat, CB);
    end
    release_out();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_key    = '0;
    in_text   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_vector("fips_b", KB, PB, CB);
    test_vector("fips_c1", KC, PC, CC);
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_reset_vs_accept();
    test_ignored_input();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
